spi_fetch_unit: RTL and testbench

//  Instruction fetch front end that feeds the control unit's instruction register.

---
 rtl/spi_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_spi_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fetch_unit.sv
// Instruction fetch front end: owns the program counter and reads bytes from a serial
// SPI ROM (mode 0, READ command + address), streaming sequential addresses without re-addressing.
module spi_fetch_unit #(
    parameter int          ADDR_W   = 16,
    parameter int          CLK_DIV  = 1,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int TX_W  = 8 + ADDR_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(ADDR_W + 8);

    typedef enum logic [2:0] {IDLE, CSGAP, CMD, ADDR, DATA, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, stream_addr_reg, pend_addr_reg;
    logic              stream_valid_reg, pend_valid_reg;
    logic [TX_W-1:0]   tx_reg;
    logic [7:0]        rx_reg, data_out_reg;
    logic              data_valid_reg, busy_reg;
    logic              cs_n_reg, sck_reg, mosi_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [1:0]        gap_cnt_reg;

    logic              shifting, tick, sck_rise, bit_end, streamable;
    logic [ADDR_W-1:0] fetch_addr, pc_inc;

    assign shifting   = (state_reg == CMD) || (state_reg == ADDR) || (state_reg == DATA);
    assign tick       = shifting && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign sck_rise   = tick && !sck_reg;
    assign bit_end    = tick && sck_reg;
    // A jump in the same cycle always forces a fresh address phase.
    assign streamable = stream_valid_reg && !cs_n_reg && !pc_load && (stream_addr_reg == pc_reg);
    assign fetch_addr = pc_load ? pc_in : pc_reg;
    assign pc_inc     = pc_reg + ADDR_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (fetch_req) state_next = streamable ? DATA : CSGAP;
            CSGAP: if (gap_cnt_reg == 2'd2) state_next = CMD;
            CMD:   if (bit_end && bit_cnt_reg == BIT_W'(7)) state_next = ADDR;
            ADDR:  if (bit_end && bit_cnt_reg == BIT_W'(ADDR_W - 1)) state_next = DATA;
            DATA:  if (bit_end && bit_cnt_reg == BIT_W'(7)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            pc_reg           <= '0;
            stream_addr_reg  <= '0;
            stream_valid_reg <= 1'b0;
            pend_addr_reg    <= '0;
            pend_valid_reg   <= 1'b0;
            tx_reg           <= '0;
            rx_reg           <= '0;
            data_out_reg     <= '0;
            data_valid_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            cs_n_reg         <= 1'b1;
            sck_reg          <= 1'b0;
            mosi_reg         <= 1'b0;
            div_cnt_reg      <= '0;
            bit_cnt_reg      <= '0;
            gap_cnt_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            data_valid_reg <= 1'b0;

            // Bit engine: each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
            if (shifting) begin
                div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
                if (tick) sck_reg <= !sck_reg;
            end
            if (sck_rise && state_reg == DATA) rx_reg <= {rx_reg[6:0], spi_miso};
            if (bit_end) begin
                bit_cnt_reg <= (state_next != state_reg) ? '0 : bit_cnt_reg + BIT_W'(1);
                if (state_reg == CMD || state_reg == ADDR) begin
                    tx_reg   <= tx_reg << 1;
                    mosi_reg <= tx_reg[TX_W-2];
                end
            end

            case (state_reg)
                IDLE: begin
                    if (pc_load) begin
                        pc_reg           <= pc_in;
                        stream_valid_reg <= 1'b0;
                    end
                    if (fetch_req) begin
                        busy_reg    <= 1'b1;
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        tx_reg      <= {READ_CMD, fetch_addr};
                        if (!streamable) begin
                            // Cold start drops CS now; a broken stream raises CS for two cycles first.
                            cs_n_reg    <= !cs_n_reg;
                            gap_cnt_reg <= cs_n_reg ? 2'd2 : 2'd0;
                        end
                    end
                end
                CSGAP: begin
                    if (gap_cnt_reg == 2'd1) cs_n_reg <= 1'b0;
                    if (gap_cnt_reg != 2'd2) gap_cnt_reg <= gap_cnt_reg + 2'd1;
                    else                     mosi_reg    <= tx_reg[TX_W-1];
                end
                DONE: begin
                    data_out_reg   <= rx_reg;
                    data_valid_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                    pend_valid_reg <= 1'b0;
                    if (pc_load) begin
                        pc_reg           <= pc_in;
                        stream_valid_reg <= 1'b0;
                    end else if (pend_valid_reg) begin
                        pc_reg           <= pend_addr_reg;
                        stream_valid_reg <= 1'b0;
                    end else begin
                        pc_reg           <= pc_inc;
                        stream_addr_reg  <= pc_inc;
                        stream_valid_reg <= (pc_inc != '0);
                    end
                end
                default: begin
                    if (pc_load) begin
                        pend_addr_reg  <= pc_in;
                        pend_valid_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign pc_out     = pc_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign busy       = busy_reg;
    assign spi_cs_n   = cs_n_reg;
    assign spi_sck    = sck_reg;
    assign spi_mosi   = mosi_reg;
endmodule

// File: tb/tb_spi_fetch_unit.sv
// Bench for spi_fetch_unit: behavioural SPI ROM, directed fetches, queue-based scoreboard
// checking data, PC and latency of every data_valid strobe.
module tb_spi_fetch_unit;
    logic        clk, rst_n, fetch_req, pc_load;
    logic [15:0] pc_in, pc_out;
    logic [7:0]  data_out;
    logic        data_valid, busy, spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] pc;
        int          vcyc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cs_hi_cnt = 0;
    int rise_cnt = 0;
    int hdr_cnt = 0;
    logic [23:0] hdr_sr = '0;
    logic [23:0] last_hdr = '0;

    spi_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_in(pc_in), .pc_out(pc_out), .data_out(data_out), .data_valid(data_valid),
        .busy(busy), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (spi_cs_n) cs_hi_cnt <= cs_hi_cnt + 1;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        if (a == 16'h0000) return 8'hA5;
        if (a == 16'h0001) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ROM: captures command+address on rising SCK, shifts data out on falling SCK.
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            rise_cnt = 0;
        end else begin
            if (rise_cnt < 24) hdr_sr = {hdr_sr[22:0], spi_mosi};
            rise_cnt++;
            if (rise_cnt == 24) begin
                last_hdr = hdr_sr;
                hdr_cnt++;
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n && rise_cnt >= 24) begin
            int k;
            logic [7:0] b;
            k = rise_cnt - 24;
            b = rom_byte(last_hdr[15:0] + 16'(k / 8));
            spi_miso = b[3'(7 - (k % 8))];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [7:0] ed, input logic [15:0] epc, input int lat,
                            input int hold, input int load_at, input logic [15:0] load_val,
                            input logic with_load);
        exp_t e;
        @(negedge clk);
        if (with_load) begin
            pc_load = 1'b1;
            pc_in   = load_val;
        end
        fetch_req = 1'b1;
        e.data = ed;
        e.pc   = epc;
        e.vcyc = cyc + 1 + lat;
        exp_q.push_back(e);
        repeat (hold) @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        if (load_at > 0) begin
            repeat (load_at - hold) @(negedge clk);
            pc_load = 1'b1;
            pc_in   = load_val;
            @(negedge clk);
            pc_load = 1'b0;
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            check("fetch_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        $display("fetch done: pc_out=0x%04h data_out=0x%02h", pc_out, data_out);
    endtask

    task automatic jump(input logic [15:0] target);
        @(negedge clk);
        pc_load = 1'b1;
        pc_in   = target;
        @(negedge clk);
        pc_load = 1'b0;
        check("pc_after_load", pc_out, target);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs_n"}, spi_cs_n, 1'b1);
        check({tag, "_sck"}, spi_sck, 1'b0);
        check({tag, "_pc"}, pc_out, 16'h0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_valid"}, data_valid, 1'b0);
    endtask

    initial begin
        int h0, c0;
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        pc_in     = '0;
        rst_n     = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && data_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", data_valid, 1'b0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("data_out", data_out, e.data);
                        check("pc_out", pc_out, e.pc);
                        check("latency_cycle", cyc, e.vcyc);
                        $display("valid: data=0x%02h pc=0x%04h cyc=%0d", data_out, pc_out, cyc);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // cold fetch at PC 0
        h0 = hdr_cnt;
        do_fetch(8'hA5, 16'h0001, 66, 1, 0, 16'h0, 1'b0);
        check("cold_hdr", last_hdr, 24'h030000);
        check("cold_hdr_cnt", hdr_cnt - h0, 1);

        // streamed fetch, fetch_req held while busy must not queue another fetch
        h0 = hdr_cnt;
        c0 = cs_hi_cnt;
        do_fetch(8'h3C, 16'h0002, 17, 5, 0, 16'h0, 1'b0);
        check("stream_cs_hi", cs_hi_cnt - c0, 0);
        check("stream_hdr_cnt", hdr_cnt - h0, 0);

        // jump in IDLE breaks the stream
        jump(16'h1234);
        c0 = cs_hi_cnt;
        do_fetch(rom_byte(16'h1234), 16'h1235, 68, 1, 0, 16'h0, 1'b0);
        check("break_cs_hi", cs_hi_cnt - c0, 2);
        check("break_hdr", last_hdr, 24'h031234);

        // jump during DATA: current byte completes, PC takes the target
        jump(16'h0010);
        do_fetch(rom_byte(16'h0010), 16'h0800, 68, 1, 60, 16'h0800, 1'b0);
        check("midload_hdr", last_hdr, 24'h030010);
        do_fetch(rom_byte(16'h0800), 16'h0801, 68, 1, 0, 16'h0, 1'b0);
        check("after_midload_hdr", last_hdr, 24'h030800);

        // jump and fetch in the same cycle
        do_fetch(rom_byte(16'h0042), 16'h0043, 68, 1, 0, 16'h0042, 1'b1);
        check("simul_hdr", last_hdr, 24'h030042);

        // PC wrap
        jump(16'hFFFF);
        do_fetch(rom_byte(16'hFFFF), 16'h0000, 68, 1, 0, 16'h0, 1'b0);
        check("wrap_hdr", last_hdr, 24'h03FFFF);
        h0 = hdr_cnt;
        do_fetch(8'hA5, 16'h0001, 68, 1, 0, 16'h0, 1'b0);
        check("post_wrap_hdr", last_hdr, 24'h030000);
        check("post_wrap_hdr_cnt", hdr_cnt - h0, 1);

        // async reset during the address phase
        jump(16'h0005);
        h0 = hdr_cnt;
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_hdr_cnt", hdr_cnt - h0, 0);
        check("abort_cs_n", spi_cs_n, 1'b1);

        // cold again after reset
        do_fetch(8'hA5, 16'h0001, 66, 1, 0, 16'h0, 1'b0);
        check("recover_hdr", last_hdr, 24'h030000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
